// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a five-stage pipeline: load-use bubble, branch flush, multi-cycle wait with timeout.
// Optional macro HAZARD_STATS_EN adds a saturating 16-bit count of fetch-stall cycles.
module pipeline_hazard_ctrl #(
    parameter int REG_W      = 4,
    parameter int MC_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_de,
    input  logic [REG_W-1:0] rs2_de,
    input  logic [REG_W-1:0] wa_ex,
    input  logic             regwrite_ex,
    input  logic             memtoreg_ex,
    input  logic             branch_taken_ex,
    input  logic             mc_start,
    input  logic             mc_done,
    output logic             stall_fe,
    output logic             stall_de,
    output logic             stall_ex,
    output logic             flush_de,
    output logic             flush_ex,
    output logic             mc_busy,
    output logic             mc_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    localparam int CW = $clog2(MC_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MC_WAIT, ERR} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          lu;

    assign lu = memtoreg_ex & regwrite_ex & ((wa_ex == rs1_de) | (wa_ex == rs2_de));

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        stall_fe   = 1'b0;
        stall_de   = 1'b0;
        stall_ex   = 1'b0;
        flush_de   = 1'b0;
        flush_ex   = 1'b0;
        mc_busy    = 1'b0;
        mc_timeout = 1'b0;
        if (!rst) begin
            mc_timeout = timeout_q;
            unique case (state_q)
                RUN: begin
                    if (branch_taken_ex) begin
                        // Redirect squashes both younger stages, including any mc_start.
                        flush_de = 1'b1;
                        flush_ex = 1'b1;
                    end else begin
                        if (lu) begin
                            stall_fe = 1'b1;
                            stall_de = 1'b1;
                            flush_ex = 1'b1;
                        end
                        if (mc_start) begin
                            state_d = MC_WAIT;
                            cnt_d   = '0;
                        end
                    end
                end
                MC_WAIT: begin
                    stall_fe = 1'b1;
                    stall_de = 1'b1;
                    stall_ex = 1'b1;
                    mc_busy  = 1'b1;
                    if (mc_done) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        // Last allowed wait cycle elapsed without a result.
                        if (cnt_q == LAST_CNT) begin
                            state_d   = ERR;
                            timeout_d = 1'b1;
                        end
                    end
                end
                ERR: begin
                    flush_de = 1'b1;
                    flush_ex = 1'b1;
                    state_d  = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_fe && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 4: register-index width.
REQ-002 Parameter MC_TIMEOUT, default 32: max cycles allowed in MC_WAIT.
REQ-003 The block SHALL run on one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rs1_de, rs2_de  in  REG_W each  source indices of the instruction in DECODE.
REQ-007 wa_ex  in  REG_W  destination index of the instruction in EXECUTE.
REQ-008 regwrite_ex, memtoreg_ex  in  1 each  EXECUTE writes a register; EXECUTE is a load.
REQ-009 branch_taken_ex  in  1  branch unit redirect from EXECUTE.
REQ-010 mc_start  in  1  multi-cycle operation entering EXECUTE.
REQ-011 mc_done  in  1  multi-cycle unit result ready.
REQ-012 stall_fe, stall_de, stall_ex  out  1 each  drive the pipeline registers' enable pins; 1 = hold value, 0 = load.
REQ-013 flush_de, flush_ex  out  1 each  drive the pipeline registers' clrBU pins; 1 = clear to 0 on the next edge.
REQ-014 mc_busy  out  1  FSM is in MC_WAIT.
REQ-015 mc_timeout  out  1  sticky error flag.

Function
REQ-016 The FSM SHALL have three states: RUN, MC_WAIT and ERR.
REQ-017 Load-use hazard: lu = memtoreg_ex & regwrite_ex & (wa_ex==rs1_de | wa_ex==rs2_de).
REQ-018 In RUN with lu=1 and branch_taken_ex=0: stall_fe=stall_de=1, flush_ex=1, same cycle (combinational); one bubble only.
REQ-019 In RUN with branch_taken_ex=1: flush_de=flush_ex=1 and all stalls=0; this overrides lu.
REQ-020 In RUN, mc_start=1 with branch_taken_ex=0 SHALL move the FSM to MC_WAIT on the next edge and clear the cycle counter.
REQ-021 In MC_WAIT: stall_fe=stall_de=stall_ex=1; flushes=0; lu and branch_taken_ex are ignored.
REQ-022 MC_WAIT with mc_done=1 SHALL return to RUN on the next edge; all stalls drop in the cycle after mc_done.
REQ-023 The counter SHALL increment each MC_WAIT cycle without mc_done.
REQ-024 Counter width: $clog2(MC_TIMEOUT+1).
REQ-025 Reaching MC_TIMEOUT without mc_done SHALL move the FSM to ERR and set mc_timeout.
REQ-026 If mc_done and timeout coincide, mc_done wins: return to RUN, no error.
REQ-027 ERR SHALL release all stalls and flush_de=flush_ex=1 for one cycle, then go to RUN; mc_timeout stays 1 until reset.
REQ-028 mc_start=1 with branch_taken_ex=1 SHALL be dropped (the instruction is flushed); the FSM stays in RUN.
REQ-029 When no hazard is present, all stall and flush outputs SHALL be 0.

Reset
REQ-030 rst=1 SHALL force: state RUN, counter 0, mc_timeout 0, all stall and flush outputs 0, mc_busy 0.
REQ-031 Reset asserted in MC_WAIT or ERR SHALL abort the operation with no residual stall in the cycle after reset is released.

Configuration
REQ-032 Macro HAZARD_STATS_EN defined: add output stall_cycles (16 bits).
- Increments on every cycle where stall_fe=1.
- Saturates at 16'hFFFF.
- Reset to 0.
REQ-033 Macro HAZARD_STATS_EN undefined: no port and no counter logic; all other behaviour is unchanged.

Verification
REQ-034 Load-use: memtoreg_ex=1, regwrite_ex=1, wa_ex=3, rs1_de=3 for one cycle -> stall_fe=stall_de=flush_ex=1 that cycle only, then all 0.
REQ-035 Branch plus load-use together: branch_taken_ex=1 with REQ-034 inputs -> flush_de=flush_ex=1, stall_fe=0.
REQ-036 Multi-cycle: mc_start pulse, mc_done after 5 cycles -> mc_busy and the stalls high 5 cycles, RUN on the next edge.
REQ-037 Timeout: mc_start, no mc_done, MC_TIMEOUT=32 -> ERR after 32 MC_WAIT cycles, one-cycle double flush, mc_timeout stays 1.
REQ-038 mc_done on the 32nd cycle -> RUN, mc_timeout=0.
REQ-039 Reset in MC_WAIT: rst at cycle 3 of the wait -> all outputs 0 after the edge; a new lu is handled normally.
